// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: line write-back FIFO between dcache and line arbiter that lets read misses bypass queued evictions
module dcache_write_buffer #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  ufp_addr,
  input  logic         ufp_read,
  input  logic         ufp_write,
  input  logic [255:0] ufp_wdata,
  output logic [255:0] ufp_rdata,
  output logic         ufp_resp,
  output logic [31:0]  dfp_addr,
  output logic         dfp_read,
  output logic         dfp_write,
  output logic [255:0] dfp_wdata,
  input  logic [255:0] dfp_rdata,
  input  logic         dfp_resp,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state;
  logic [DEPTH-1:0] valid;
  logic [26:0] tags [DEPTH];
  logic [255:0] lines [DEPTH];
  logic [PW-1:0] head, tail, idx, rd_idx, co_idx;
  logic [PW:0] count;
  logic rd_req, wr_req, rd_hit, co_hit, pop, push, unused_bits;
  assign wr_req = ufp_write && !ufp_resp;
  assign rd_req = ufp_read && !ufp_write && !ufp_resp && state != READ;
  assign pop = state == DRAIN && dfp_resp;
  assign push = wr_req && !co_hit && (count < FULL || pop);
  assign empty = count == '0 && state == IDLE;
  assign unused_bits = ^ufp_addr[4:0];
  always_comb begin
    rd_hit = 1'b0;
    rd_idx = '0;
    co_hit = 1'b0;
    co_idx = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && tags[idx] == ufp_addr[31:5]) begin
        rd_hit = 1'b1;
        rd_idx = idx;
        if (!(state == DRAIN && idx == head)) begin
          co_hit = 1'b1;
          co_idx = idx;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      ufp_resp <= 1'b0;
      ufp_rdata <= '0;
      dfp_read <= 1'b0;
      dfp_write <= 1'b0;
      dfp_addr <= '0;
      dfp_wdata <= '0;
    end else begin
      ufp_resp <= (rd_req && rd_hit) || (wr_req && co_hit) || push;
      if (rd_req && rd_hit) ufp_rdata <= lines[rd_idx];
      if (state == IDLE && rd_req && !rd_hit) begin
        state <= READ;
        dfp_read <= 1'b1;
        dfp_addr <= {ufp_addr[31:5], 5'b0};
      end else if (state == IDLE && count != '0) begin
        state <= DRAIN;
        dfp_write <= 1'b1;
        dfp_addr <= {tags[head], 5'b0};
        dfp_wdata <= wr_req && co_hit && co_idx == head ? ufp_wdata : lines[head];
      end else if (state == READ && dfp_resp) begin
        state <= IDLE;
        dfp_read <= 1'b0;
        ufp_resp <= 1'b1;
        ufp_rdata <= dfp_rdata;
      end else if (pop) begin
        state <= IDLE;
        dfp_write <= 1'b0;
        valid[head] <= 1'b0;
        head <= head + 1'b1;
      end
      if (wr_req && co_hit) lines[co_idx] <= ufp_wdata;
      if (push) begin
        tags[tail] <= ufp_addr[31:5];
        lines[tail] <= ufp_wdata;
        valid[tail] <= 1'b1;
        tail <= tail + 1'b1;
      end
      count <= count + {PW'(0), push} - {PW'(0), pop};
    end
  end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: table vectors, directed corner sequences and a random coherency test against a line-memory model
module tb_dcache_write_buffer;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] ufp_addr, dfp_addr;
  logic ufp_read, ufp_write, ufp_resp, dfp_read, dfp_write, dfp_resp, empty;
  logic [255:0] ufp_wdata, ufp_rdata, dfp_wdata, dfp_rdata;
  always #5 clk = ~clk;
  dcache_write_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .ufp_addr(ufp_addr), .ufp_read(ufp_read), .ufp_write(ufp_write),
    .ufp_wdata(ufp_wdata), .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp), .dfp_addr(dfp_addr),
    .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata),
    .dfp_resp(dfp_resp), .empty(empty)
  );
  typedef struct {
    bit we;
    logic [31:0] addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
    int lat;
  } vec_t;
  localparam logic [255:0] LA = {8{32'haaaa_0001}};
  localparam logic [255:0] LB = {8{32'hbbbb_0002}};
  localparam logic [255:0] LC = {8{32'hcccc_0003}};
  localparam logic [255:0] LD = {8{32'hdddd_0004}};
  localparam logic [255:0] LX = {8{32'h1234_5678}};
  vec_t vecs [7];
  int checks = 0, failures = 0;
  bit auto_en = 1'b0, go = 1'b0, req_act = 1'b0;
  int lat_cfg = 0, wait_cnt = 0, rd_cycles = 0;
  logic [31:0] req_addr;
  logic [255:0] req_wdata;
  logic [255:0] mem [logic [26:0]];
  logic [255:0] shadow [logic [26:0]];
  function automatic logic [255:0] mem_init(input logic [26:0] t);
    return {8{{5'b0, t} ^ 32'h5a5a_0000}};
  endfunction
  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  initial begin
    dfp_resp = 1'b0;
    dfp_rdata = '0;
    forever begin
      @(negedge clk);
      if (dfp_read) rd_cycles++;
      if ((dfp_read || dfp_write) && !req_act && !dfp_resp) begin
        req_act = 1'b1;
        req_addr = dfp_addr;
        req_wdata = dfp_wdata;
      end
      if (dfp_resp) begin
        dfp_resp = 1'b0;
        wait_cnt = 0;
      end else if (go || (auto_en && (dfp_read || dfp_write) && wait_cnt >= lat_cfg)) begin
        go = 1'b0;
        if (dfp_read || dfp_write) begin
          chk("dfp_excl", 256'(dfp_read && dfp_write), 256'(0));
          chk("dfp_addr_lo", 256'(dfp_addr[4:0]), 256'(0));
          chk("dfp_addr_stable", 256'(dfp_addr), 256'(req_addr));
          if (dfp_write) begin
            chk("dfp_wdata_stable", dfp_wdata, req_wdata);
            mem[dfp_addr[31:5]] = dfp_wdata;
          end else dfp_rdata = mem.exists(dfp_addr[31:5]) ? mem[dfp_addr[31:5]] : mem_init(dfp_addr[31:5]);
        end
        req_act = 1'b0;
        dfp_resp = 1'b1;
        lat_cfg = $urandom_range(0, 3);
      end else if (dfp_read || dfp_write) wait_cnt++;
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    auto_en = 1'b0;
    go = 1'b0;
    {ufp_read, ufp_write, ufp_addr, ufp_wdata} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    req_act = 1'b0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ufp_resp"}, 256'(ufp_resp), 256'(0));
    chk({tag, "_dfp_read"}, 256'(dfp_read), 256'(0));
    chk({tag, "_dfp_write"}, 256'(dfp_write), 256'(0));
    chk({tag, "_ufp_rdata"}, ufp_rdata, 256'(0));
    chk({tag, "_dfp_addr"}, 256'(dfp_addr), 256'(0));
    chk({tag, "_dfp_wdata"}, dfp_wdata, 256'(0));
    chk({tag, "_empty"}, 256'(empty), 256'(1));
  endtask
  task automatic req_start(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] d);
    ufp_read = rd;
    ufp_write = wr;
    ufp_addr = a;
    ufp_wdata = d;
  endtask
  task automatic wait_resp(output int lat, output logic [255:0] data);
    lat = -1;
    data = '0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (ufp_resp) begin
        lat = i;
        data = ufp_rdata;
        break;
      end
    end
    ufp_read = 1'b0;
    ufp_write = 1'b0;
    @(negedge clk);
  endtask
  task automatic xact(input string name, input bit wr, input logic [31:0] a, input logic [255:0] d,
                      input int exp_lat, input logic [255:0] exp_data);
    int lat;
    logic [255:0] data;
    req_start(!wr, wr, a, d);
    wait_resp(lat, data);
    chk({name, "_lat"}, 256'(lat), 256'(exp_lat));
    if (!wr) chk({name, "_data"}, data, exp_data);
  endtask
  task automatic release_drain();
    #1 go = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic expect_drain(input string name, input logic [31:0] a, input logic [255:0] d);
    int n = 0;
    while (!dfp_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_write"}, 256'(dfp_write), 256'(1));
    chk({name, "_addr"}, 256'(dfp_addr), 256'(a));
    chk({name, "_data"}, dfp_wdata, d);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, n, bad, rd_base;
    logic [255:0] data, d;
    logic [26:0] t;
    bit rd, wr;
    vecs[0] = '{1'b1, 32'h0000_1000, LA, '0, 1};
    vecs[1] = '{1'b0, 32'h0000_1010, '0, LA, 1};
    vecs[2] = '{1'b1, 32'h0000_2000, LB, '0, 1};
    vecs[3] = '{1'b0, 32'h0000_2000, '0, LB, 1};
    vecs[4] = '{1'b1, 32'h0000_2008, LD, '0, 1};
    vecs[5] = '{1'b0, 32'h0000_201f, '0, LD, 1};
    vecs[6] = '{1'b0, 32'h0000_1000, '0, LA, 1};
    do_reset();
    chk_reset_outputs("rst");
    rd_base = rd_cycles;
    for (int i = 0; i < 7; i++)
      xact($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].lat, vecs[i].rdata);
    chk("tbl_no_dfp_read", 256'(rd_cycles - rd_base), 256'(0));
    expect_drain("tbl_drain1", 32'h1000, LA);
    release_drain();
    expect_drain("tbl_drain2", 32'h2000, LD);
    release_drain();
    chk("tbl_empty", 256'(empty), 256'(1));
    do_reset();
    xact("r33_wr", 1'b1, 32'h1000, LA, 1, '0);
    expect_drain("r33_drain", 32'h1000, LA);
    chk("r33_busy", 256'(empty), 256'(0));
    release_drain();
    chk("r33_empty", 256'(empty), 256'(1));
    do_reset();
    xact("r34_w1", 1'b1, 32'h1000, LA, 1, '0);
    xact("r34_w2", 1'b1, 32'h2000, LB, 1, '0);
    req_start(1'b0, 1'b1, 32'h3000, LC);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (ufp_resp) bad++;
    end
    chk("r34_stalled", 256'(bad), 256'(0));
    #1 go = 1'b1;
    wait_resp(lat, data);
    chk("r34_accept_lat", 256'(lat), 256'(2));
    expect_drain("r34_d2", 32'h2000, LB);
    release_drain();
    expect_drain("r34_d3", 32'h3000, LC);
    release_drain();
    chk("r34_empty", 256'(empty), 256'(1));
    do_reset();
    xact("r36_wr", 1'b1, 32'h1000, LA, 1, '0);
    req_start(1'b1, 1'b0, 32'h4000, '0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (dfp_read || ufp_resp) bad++;
    end
    chk("r36_read_waits", 256'(bad), 256'(0));
    #1 go = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dfp_read && n < 10);
    chk("r36_read_issue", 256'(n), 256'(3));
    chk("r36_read_addr", 256'(dfp_addr), 256'(32'h4000));
    #1 go = 1'b1;
    wait_resp(lat, data);
    chk("r36_resp_lat", 256'(lat), 256'(2));
    chk("r36_resp_data", data, mem_init(27'h200));
    do_reset();
    xact("r37_wx", 1'b1, 32'h2000, LX, 1, '0);
    xact("r37_wa", 1'b1, 32'h1000, LA, 1, '0);
    xact("r37_wc_full", 1'b1, 32'h1000, LC, 1, '0);
    expect_drain("r37_dx", 32'h2000, LX);
    release_drain();
    expect_drain("r37_dc", 32'h1000, LC);
    release_drain();
    chk("r37_single", 256'(empty), 256'(1));
    xact("r37_wa2", 1'b1, 32'h1000, LA, 1, '0);
    xact("r37_wc2", 1'b1, 32'h1000, LC, 1, '0);
    expect_drain("r37_flight_a", 32'h1000, LA);
    release_drain();
    expect_drain("r37_flight_c", 32'h1000, LC);
    release_drain();
    chk("r37_empty", 256'(empty), 256'(1));
    do_reset();
    xact("r38_wr", 1'b1, 32'h1000, LA, 1, '0);
    chk("r38_draining", 256'(dfp_write), 256'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("r38");
    #1 go = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (ufp_resp || dfp_read || dfp_write || !empty) bad++;
    end
    chk("r38_late_resp", 256'(bad), 256'(0));
    do_reset();
    mem.delete();
    shadow.delete();
    auto_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      t = 27'h400 + 27'($urandom_range(0, 3));
      n = $urandom_range(0, 9);
      wr = n >= 4;
      rd = n < 4 || n == 9;
      d = rand_line();
      req_start(rd, wr, {t, 5'($urandom)}, d);
      wait_resp(lat, data);
      chk("rnd_resp", 256'(lat > 0), 256'(1));
      if (wr) shadow[t] = d;
      else chk("rnd_rdata", data, shadow.exists(t) ? shadow[t] : mem_init(t));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n = 0;
    while (!empty && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rnd_drained", 256'(empty), 256'(1));
    for (int i = 0; i < 4; i++) begin
      t = 27'h400 + 27'(i);
      if (shadow.exists(t)) chk($sformatf("rnd_mem%0d", i), mem.exists(t) ? mem[t] : mem_init(t), shadow[t]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
